cluster_loader: RTL and testbench

- Command-stream front end that drives the sprite cluster's write port (waddr/wdata/wen).
- Accepts 16-bit words over a valid/ready stream from the host bridge and decodes sprite-descriptor, texture-upload and clear commands.
- Emits at most one registered cluster write per cycle.
- Sits between the host interface and the GPU cluster. It is the initiator for the cluster's write-only register/texture space.

---
 rtl/gpu_pkg.sv | 33 +++
 rtl/cluster_loader.sv | 162 ++++++++++++++++
 tb/tb_cluster_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared opcodes, sprite field indices and loader states.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SPRITE  = 2'b01,
    OP_TEXTURE = 2'b10,
    OP_CLEAR   = 2'b11
  } opcode_t;

  localparam int F_SX              = 0;
  localparam int F_SY              = 1;
  localparam int F_STX             = 2;
  localparam int F_STY             = 3;
  localparam int F_STW             = 4;
  localparam int F_STH             = 5;
  localparam int FIELDS_PER_SPRITE = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPR_DATA = 3'd1,
    TEX_OFFS = 3'd2,
    TEX_DATA = 3'd3,
    CLEAR    = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/cluster_loader.sv
`default_nettype none
// ============================================================================
// Module      : cluster_loader
// Description : Decodes the host command stream into single-cycle writes on
//               the sprite cluster's register/texture write port.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_loader
  import gpu_pkg::*;
#(
  parameter int CLUSTER_SIZE   = 10,
  parameter int TEXTURE_WIDTH  = 64,
  parameter int TEXTURE_HEIGHT = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int INT_WIDTH      = 16,
  parameter int COLOR_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INT_WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [INT_WIDTH-1:0]  wdata,
  output logic                  wen,
  output logic                  busy,
  output logic                  err
);

  localparam logic [16:0]           c_tex_size  = 17'(TEXTURE_WIDTH * TEXTURE_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] c_tex_base  = ADDR_WIDTH'(CLUSTER_SIZE * FIELDS_PER_SPRITE);
  localparam logic [ADDR_WIDTH-1:0] c_clr_last  = ADDR_WIDTH'(CLUSTER_SIZE * FIELDS_PER_SPRITE - 1);
  localparam logic [13:0]           c_idx_limit = 14'(CLUSTER_SIZE);
  localparam logic [2:0]            c_fld_last  = 3'(FIELDS_PER_SPRITE - 1);

  loader_state_t         r_state;
  logic [13:0]           r_idx;
  logic                  r_discard;
  logic [2:0]            r_fcnt;
  logic [INT_WIDTH-1:0]  r_offs;
  logic [13:0]           r_pcnt;
  logic [13:0]           r_plast;
  logic [ADDR_WIDTH-1:0] r_ccnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [INT_WIDTH-1:0]  r_wdata;
  logic                  r_wen;
  logic                  r_err;

  opcode_t               w_op;
  logic [13:0]           w_arg;
  logic                  w_ready;
  logic                  w_accept;
  logic [16:0]           w_t;
  logic                  w_tex_ok;
  logic                  w_hdr_bad;
  logic                  w_err_set;
  logic [ADDR_WIDTH-1:0] w_spr_addr;
  logic [ADDR_WIDTH-1:0] w_tex_addr;

  assign w_op       = opcode_t'(in_data[15:14]);
  assign w_arg      = in_data[13:0];
  assign w_ready    = (r_state != CLEAR);
  assign w_accept   = in_valid & w_ready;
  // Texel offset is formed one bit wider than the stream so it never wraps.
  assign w_t        = 17'(r_offs) + 17'(r_pcnt);
  assign w_tex_ok   = (w_t < c_tex_size);
  assign w_hdr_bad  = (r_state == IDLE) && (w_op == OP_SPRITE) && (w_arg >= c_idx_limit);
  assign w_err_set  = w_accept && (w_hdr_bad || ((r_state == TEX_DATA) && !w_tex_ok));
  assign w_spr_addr = ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(FIELDS_PER_SPRITE) + ADDR_WIDTH'(r_fcnt);
  assign w_tex_addr = c_tex_base + ADDR_WIDTH'(w_t);

  assign in_ready = w_ready;
  assign busy     = (r_state != IDLE);
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign wen      = r_wen;
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_discard <= 1'b0;
      r_fcnt    <= '0;
      r_offs    <= '0;
      r_pcnt    <= '0;
      r_plast   <= '0;
      r_ccnt    <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      r_err <= w_err_set | (r_err & ~err_clr);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_SPRITE: begin
                r_idx     <= w_arg;
                r_discard <= (w_arg >= c_idx_limit);
                r_fcnt    <= '0;
                r_state   <= SPR_DATA;
              end
              OP_TEXTURE: begin
                r_plast <= w_arg;
                r_state <= TEX_OFFS;
              end
              OP_CLEAR: begin
                r_ccnt  <= '0;
                r_state <= CLEAR;
              end
              default: ;
            endcase
          end
        end
        SPR_DATA: begin
          if (w_accept) begin
            // A discarded sprite still consumes its words but leaves the port untouched.
            if (!r_discard) begin
              r_waddr <= w_spr_addr;
              r_wdata <= in_data;
              r_wen   <= 1'b1;
            end
            r_fcnt <= r_fcnt + 3'd1;
            if (r_fcnt == c_fld_last) r_state <= IDLE;
          end
        end
        TEX_OFFS: begin
          if (w_accept) begin
            r_offs  <= in_data;
            r_pcnt  <= '0;
            r_state <= TEX_DATA;
          end
        end
        TEX_DATA: begin
          if (w_accept) begin
            if (w_tex_ok) begin
              r_waddr <= w_tex_addr;
              r_wdata <= INT_WIDTH'(in_data[COLOR_WIDTH-1:0]);
              r_wen   <= 1'b1;
            end
            r_pcnt <= r_pcnt + 14'd1;
            if (r_pcnt == r_plast) r_state <= IDLE;
          end
        end
        CLEAR: begin
          r_waddr <= r_ccnt;
          r_wdata <= '0;
          r_wen   <= 1'b1;
          r_ccnt  <= r_ccnt + 1'b1;
          if (r_ccnt == c_clr_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cluster_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_loader
// Description : Directed self-checking bench for cluster_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        err_clr = 1'b0;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        wen;
  logic        busy;
  logic        err;

  cluster_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .err_clr  (err_clr),
    .waddr    (waddr),
    .wdata    (wdata),
    .wen      (wen),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level reference: what the cluster port must show after each edge.
  int m_kind  = 0;   // 0 header, 1 sprite data, 2 texture offset, 3 texture pixels
  int m_idx   = 0;
  int m_pos   = 0;
  int m_n     = 0;
  int m_offs  = 0;
  int m_clear = 0;
  int m_wen   = 0;
  int m_waddr = 0;
  int m_wdata = 0;
  int m_err   = 0;

  always @(posedge clk) begin
    int op, arg, t, set;
    if (!rst) begin
      m_kind = 0; m_clear = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
    end else begin
      set   = 0;
      m_wen = 0;
      if (m_clear > 0) begin
        m_wen = 1; m_waddr = 60 - m_clear; m_wdata = 0; m_clear--;
      end else if (in_valid) begin
        case (m_kind)
          0: begin
            op  = int'(in_data) >> 14;
            arg = int'(in_data) & 'h3fff;
            if (op == 1) begin
              m_kind = 1; m_idx = arg; m_pos = 0;
              if (arg >= 10) set = 1;
            end else if (op == 2) begin
              m_kind = 2; m_n = arg + 1;
            end else if (op == 3) begin
              m_clear = 60;
            end
          end
          1: begin
            if (m_idx < 10) begin
              m_wen = 1; m_waddr = m_idx * 6 + m_pos; m_wdata = int'(in_data);
            end
            m_pos++;
            if (m_pos == 6) m_kind = 0;
          end
          2: begin
            m_offs = int'(in_data); m_pos = 0; m_kind = 3;
          end
          default: begin
            t = m_offs + m_pos;
            if (t < 4096) begin
              m_wen = 1; m_waddr = 60 + t; m_wdata = int'(in_data) & 'hfff;
            end else begin
              set = 1;
            end
            m_pos++;
            if (m_pos == m_n) m_kind = 0;
          end
        endcase
      end
      if (set == 1) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  logic [15:0] la[$];
  logic [15:0] ld[$];

  always @(negedge clk) begin
    check("wen", 32'(wen), 32'(m_wen));
    check("waddr", 32'(waddr), 32'(m_waddr));
    check("wdata", 32'(wdata), 32'(m_wdata));
    check("err", 32'(err), 32'(m_err));
    check("busy", 32'(busy), 32'((m_kind != 0) || (m_clear > 0)));
    check("in_ready", 32'(in_ready), 32'(m_clear == 0));
    if (wen === 1'b1) begin
      la.push_back(waddr);
      ld.push_back(wdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic word(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clr_log();
    la.delete(); ld.delete();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  logic [15:0] spr_words[6] = '{16'd100, 16'd50, 16'd0, 16'd16, 16'd16, 16'd16};
  logic [15:0] tex_words[5] = '{16'd4094, 16'hFABC, 16'h0123, 16'h0456, 16'h0789};

  initial begin
    int k;
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    rst = 1'b1;
    idle(1);

    // NOP
    clr_log();
    word(16'h0000);
    idle(2);
    check("nop_busy", 32'(busy), 32'd0);
    check("nop_writes", 32'(la.size()), 32'd0);

    // SPRITE idx 3
    clr_log();
    word(16'h4003);
    foreach (spr_words[i]) word(spr_words[i]);
    idle(2);
    check("spr_writes", 32'(la.size()), 32'd6);
    if (la.size() == 6) begin
      check("spr_a0", 32'(la[0]), 32'd18);
      check("spr_d0", 32'(ld[0]), 32'd100);
      check("spr_a1", 32'(la[1]), 32'd19);
      check("spr_d1", 32'(ld[1]), 32'd50);
      check("spr_a5", 32'(la[5]), 32'd23);
      check("spr_d5", 32'(ld[5]), 32'd16);
    end
    check("spr_err", 32'(err), 32'd0);

    // TEXTURE crossing the end of the atlas
    clr_log();
    word(16'h8003);
    foreach (tex_words[i]) word(tex_words[i]);
    idle(2);
    check("tex_writes", 32'(la.size()), 32'd2);
    if (la.size() == 2) begin
      check("tex_a0", 32'(la[0]), 32'd4154);
      check("tex_d0", 32'(ld[0]), 32'h0ABC);
      check("tex_a1", 32'(la[1]), 32'd4155);
      check("tex_d1", 32'(ld[1]), 32'h0123);
    end
    check("tex_err", 32'(err), 32'd1);
    check("tex_busy", 32'(busy), 32'd0);
    pulse_err_clr();
    check("tex_errclr", 32'(err), 32'd0);

    // CLEAR
    clr_log();
    word(16'hC000);
    check("clr_ready", 32'(in_ready), 32'd0);
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("clr_cycles", 32'(k), 32'd60);
    idle(1);
    check("clr_writes", 32'(la.size()), 32'd60);
    if (la.size() == 60) begin
      check("clr_a0", 32'(la[0]), 32'd0);
      check("clr_a59", 32'(la[59]), 32'd59);
      check("clr_d59", 32'(ld[59]), 32'd0);
    end
    check("clr_ready_end", 32'(in_ready), 32'd1);

    // Bad sprite index
    clr_log();
    word(16'h400A);
    for (int i = 0; i < 6; i++) word(16'(i + 1));
    idle(2);
    check("bad_writes", 32'(la.size()), 32'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    pulse_err_clr();
    check("bad_errclr", 32'(err), 32'd0);
    err_clr = 1'b1;
    word(16'h400B);
    err_clr = 1'b0;
    check("bad_setwins", 32'(err), 32'd1);
    for (int i = 0; i < 6; i++) word(16'h1111);
    pulse_err_clr();
    check("bad_errclr2", 32'(err), 32'd0);

    // Stalls, then reset mid-command
    clr_log();
    word(16'h4000);
    word(16'hA000); idle(2);
    word(16'hA001); idle(2);
    word(16'hA002);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("rst_mid_wen", 32'(wen), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("stall_writes", 32'(la.size()), 32'd3);
    if (la.size() == 3) begin
      check("stall_a2", 32'(la[2]), 32'd2);
      check("stall_d2", 32'(ld[2]), 32'hA002);
    end
    clr_log();
    word(16'h4001);
    for (int i = 0; i < 6; i++) word(16'(16'h0200 + i));
    idle(2);
    check("post_writes", 32'(la.size()), 32'd6);
    if (la.size() == 6) begin
      check("post_a0", 32'(la[0]), 32'd6);
      check("post_a5", 32'(la[5]), 32'd11);
      check("post_d5", 32'(ld[5]), 32'h0205);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
